// File: rtl/mux_n_1_arb_reg_pkg.sv
// Shared constants and helpers for the arbitrated N:1 selector.
package mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_1_arb_reg_if.sv
// Request/response bundle between the channel sources and the
// arbitrated register stage.
interface mux_n_1_arb_reg_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int SELW = clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SELW-1:0]    force_sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux_n_1_arb_reg_rr_arbiter.sv
// Combinational arbiter: fixed priority from ch0, or a
// round-robin scan starting at i_ptr.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    i_valid,
    input  logic [SELW-1:0] i_ptr,
    input  logic            i_mode,
    output logic [N-1:0]    o_grant,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);

    always_comb begin : p_scan
        int              w_j;
        logic [SELW-1:0] w_cand;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_j = i_mode ? int'(i_ptr) + k : k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_cand = SELW'(w_j);
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_arb_reg.sv
// N-channel arbitrated selector with a registered valid/ready
// output stage; select comes from the arbiter or a forced index.
module mux_n_1_arb_reg
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int N        = 4,
    parameter int ARB_MODE = ARB_FIXED
) (
    input logic              clk,
    input logic              rst,
    mux_n_1_arb_reg_if.slave bus
);

    localparam int SELW = clog2(N);

    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_sel;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    logic             w_load;
    logic             w_xfer;
    logic             w_arb_any;
    logic [N-1:0]     w_arb_grant;
    logic [N-1:0]     w_grant;
    logic [N-1:0]     w_ready;
    logic [SELW-1:0]  w_arb_idx;
    logic [SELW-1:0]  w_idx;
    logic [WIDTH-1:0] w_data;

    rr_arbiter #(.N(N)) u_arb (
        .i_valid (bus.in_valid),
        .i_ptr   (r_ptr),
        .i_mode  (ARB_MODE == ARB_RR),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // A forced index outside the channel range grants nobody.
    always_comb begin
        w_grant = '0;
        if (bus.force_en) begin
            if (int'(bus.force_sel) < N) begin
                w_grant[bus.force_sel] = bus.in_valid[bus.force_sel];
            end
        end else if (w_arb_any) begin
            w_grant = w_arb_grant;
        end
    end

    assign w_idx   = bus.force_en ? bus.force_sel : w_arb_idx;
    assign w_load  = !r_valid || bus.out_ready;
    assign w_ready = (w_load && !rst) ? w_grant : '0;
    assign w_xfer  = |(w_ready & bus.in_valid);

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_sel   <= w_idx;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
            // Forced transfers must not disturb round-robin fairness.
            if (w_xfer && !bus.force_en) begin
                r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;

    for (genvar gi = 0; gi < N; gi++) begin : g_src
        a_hold: assert property (@(posedge clk) disable iff (rst)
            bus.in_valid[gi] && !bus.in_ready[gi] |=>
            bus.in_valid[gi] && $stable(bus.in_data[gi*WIDTH +: WIDTH]));
    end

endmodule

// File: tb/tb_mux_n_1_arb_reg.sv
// Bench: fixed-priority and round-robin instances checked against
// a behavioural model, directed scenarios then random traffic.
module tb_mux_n_1_arb_reg;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]  vin  [2];
    logic [63:0] din  [2];
    logic        fen  [2];
    logic [1:0]  fsel [2];
    logic        ordy [2];

    logic [3:0]  rdy [2];
    logic        ov  [2];
    logic [15:0] od  [2];
    logic [1:0]  os  [2];

    logic        mv [2];
    logic [15:0] md [2];
    int          ms [2];
    int          mp [2];
    logic [3:0]  dmask [2];
    bit          rnd;

    int total;
    int bad;

    mux_n_1_arb_reg_if #(.WIDTH(16), .N(4)) ifc0 ();
    mux_n_1_arb_reg_if #(.WIDTH(16), .N(4)) ifc1 ();

    mux_n_1_arb_reg #(.WIDTH(16), .N(4), .ARB_MODE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0)
    );

    mux_n_1_arb_reg #(.WIDTH(16), .N(4), .ARB_MODE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    assign ifc0.in_valid  = vin[0];
    assign ifc0.in_data   = din[0];
    assign ifc0.force_en  = fen[0];
    assign ifc0.force_sel = fsel[0];
    assign ifc0.out_ready = ordy[0];
    assign rdy[0] = ifc0.in_ready;
    assign ov[0]  = ifc0.out_valid;
    assign od[0]  = ifc0.out_data;
    assign os[0]  = ifc0.out_sel;

    assign ifc1.in_valid  = vin[1];
    assign ifc1.in_data   = din[1];
    assign ifc1.force_en  = fen[1];
    assign ifc1.force_sel = fsel[1];
    assign ifc1.out_ready = ordy[1];
    assign rdy[1] = ifc1.in_ready;
    assign ov[1]  = ifc1.out_valid;
    assign od[1]  = ifc1.out_data;
    assign os[1]  = ifc1.out_sel;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner by the arbitration rules; -1 when nobody may win.
    function automatic int pick(input int d);
        int j;
        if (fen[d]) begin
            return vin[d][fsel[d]] ? int'(fsel[d]) : -1;
        end
        for (int k = 0; k < 4; k++) begin
            j = (d == 1) ? (mp[d] + k) % 4 : k;
            if (vin[d][j]) return j;
        end
        return -1;
    endfunction

    task automatic step();
        logic [3:0]  acc [2];
        logic        nv  [2];
        logic [15:0] nd  [2];
        int          ns  [2];
        int          np  [2];
        logic [3:0]  er;
        int          g;
        #1;
        for (int d = 0; d < 2; d++) begin
            g  = pick(d);
            er = (!rst && (!mv[d] || ordy[d]) && g >= 0) ? 4'(1 << g) : 4'b0;
            chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(er));
            chk($sformatf("ov%0d", d), 32'(ov[d]), 32'(mv[d]));
            chk($sformatf("od%0d", d), 32'(od[d]), 32'(md[d]));
            chk($sformatf("os%0d", d), 32'(os[d]), 32'(ms[d]));
            acc[d] = vin[d] & er;
            nv[d] = mv[d];
            nd[d] = md[d];
            ns[d] = ms[d];
            np[d] = mp[d];
            if (rst) begin
                nv[d] = 1'b0;
                nd[d] = 16'h0;
                ns[d] = 0;
                np[d] = 0;
            end else if (er != 4'b0) begin
                nv[d] = 1'b1;
                nd[d] = din[d][g*16 +: 16];
                ns[d] = g;
                if (!fen[d]) np[d] = (g + 1) % 4;
            end else if (ordy[d]) begin
                nv[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mv[d] = nv[d];
            md[d] = nd[d];
            ms[d] = ns[d];
            mp[d] = np[d];
            for (int i = 0; i < 4; i++) begin
                if (acc[d][i]) begin
                    if (rnd) begin
                        if ($urandom_range(1) == 1)
                            din[d][i*16 +: 16] = 16'($urandom);
                        else
                            vin[d][i] = 1'b0;
                    end else if (dmask[d][i]) begin
                        vin[d][i] = 1'b0;
                    end
                end else if (rnd && !vin[d][i] && $urandom_range(2) == 0) begin
                    vin[d][i] = 1'b1;
                    din[d][i*16 +: 16] = 16'($urandom);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        for (int d = 0; d < 2; d++) begin
            dmask[d] = 4'b1111;
            fen[d]   = 1'b0;
            ordy[d]  = 1'b1;
        end
        while (((vin[0] | vin[1]) != 4'b0 || mv[0] || mv[1]) && n < 30) begin
            step();
            n++;
        end
        chk("drain_busy", {vin[0], vin[1]}, 32'h0);
        chk("drain_ov", {ov[0], ov[1]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int rr_exp [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
    int p;

    initial begin
        total = 0;
        bad   = 0;
        rnd   = 1'b0;
        rst   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin[d]   = 4'b1111;
            din[d]   = 64'h1003_1002_1001_1000;
            fen[d]   = 1'b0;
            fsel[d]  = 2'd0;
            ordy[d]  = 1'b1;
            dmask[d] = 4'b1111;
            mv[d]    = 1'b0;
            md[d]    = 16'h0;
            ms[d]    = 0;
            mp[d]    = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        repeat (3) begin
            #1 chk("rst_rdy", 32'(rdy[0]), 32'h0);
            step();
            chk("rst_ov", 32'(ov[0]), 32'h0);
            chk("rst_od", 32'(od[0]), 32'h0);
        end
        rst = 1'b0;
        #1 chk("rst_first", 32'(rdy[0]), 32'b0001);
        drain();

        vin[0] = 4'b1010;
        din[0][16 +: 16] = 16'h1234;
        din[0][48 +: 16] = 16'h5678;
        #1 chk("fp_rdy", 32'(rdy[0]), 32'b0010);
        step();
        chk("fp_sel1", 32'(os[0]), 32'd1);
        chk("fp_dat1", 32'(od[0]), 32'h1234);
        step();
        chk("fp_ov3", 32'(ov[0]), 32'd1);
        chk("fp_sel3", 32'(os[0]), 32'd3);
        chk("fp_dat3", 32'(od[0]), 32'h5678);
        drain();

        for (int i = 0; i < 4; i++) din[1][i*16 +: 16] = 16'(16'h1111 * i);
        dmask[1] = 4'b0000;
        vin[1]   = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) dmask[1] = 4'b0010;
            step();
            chk("rr_seq", 32'(os[1]), 32'(rr_exp[k]));
            chk("rr_dat", 32'(od[1]), 32'(16'(16'h1111 * rr_exp[k])));
        end
        drain();

        vin[0] = 4'b0011;
        din[0][0 +: 16]  = 16'h1234;
        din[0][16 +: 16] = 16'h4321;
        step();
        chk("bp_first", 32'(od[0]), 32'h1234);
        ordy[0] = 1'b0;
        repeat (5) begin
            #1 chk("bp_rdy", 32'(rdy[0]), 32'h0);
            step();
            chk("bp_hold", 32'(od[0]), 32'h1234);
            chk("bp_ov", 32'(ov[0]), 32'd1);
        end
        ordy[0] = 1'b1;
        #1 chk("bp_rel_rdy", 32'(rdy[0]), 32'b0010);
        step();
        chk("bp_next", 32'(od[0]), 32'h4321);
        chk("bp_next_sel", 32'(os[0]), 32'd1);
        drain();

        p = mp[1];
        for (int i = 0; i < 4; i++) din[1][i*16 +: 16] = 16'(16'hA000 + i);
        din[1][32 +: 16] = 16'hABCD;
        dmask[1] = 4'b0000;
        vin[1]   = 4'b1111;
        fen[1]   = 1'b1;
        fsel[1]  = 2'd2;
        #1 chk("frc_rdy", 32'(rdy[1]), 32'b0100);
        step();
        chk("frc_dat", 32'(od[1]), 32'hABCD);
        chk("frc_sel", 32'(os[1]), 32'd2);
        fsel[1]  = 2'd3;
        dmask[1] = 4'b1000;
        step();
        chk("frc_sel3", 32'(os[1]), 32'd3);
        #1 chk("frc_none", 32'(rdy[1]), 32'h0);
        step();
        chk("frc_none_ov", 32'(ov[1]), 32'd0);
        fen[1]   = 1'b0;
        dmask[1] = 4'b1111;
        step();
        chk("frc_ptr", 32'(os[1]), 32'((p == 3) ? 0 : p));
        drain();

        vin[0] = 4'b0011;
        din[0][0 +: 16]  = 16'hBEEF;
        din[0][16 +: 16] = 16'hCAFE;
        step();
        chk("mr_ov", 32'(ov[0]), 32'd1);
        chk("mr_od", 32'(od[0]), 32'hBEEF);
        ordy[0] = 1'b0;
        step();
        chk("mr_stall", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        #1 chk("mr_rdy", 32'(rdy[0]), 32'h0);
        step();
        chk("mr_ov_clr", 32'(ov[0]), 32'd0);
        chk("mr_od_clr", 32'(od[0]), 32'h0);
        rst     = 1'b0;
        ordy[0] = 1'b1;
        #1 chk("mr_rel_rdy", 32'(rdy[0]), 32'b0010);
        step();
        chk("mr_next", 32'(od[0]), 32'hCAFE);
        drain();

        rnd = 1'b1;
        repeat (400) begin
            for (int d = 0; d < 2; d++) begin
                ordy[d] = ($urandom_range(3) != 0);
                fen[d]  = ($urandom_range(7) == 0);
                fsel[d] = 2'($urandom);
            end
            step();
        end
        rnd = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
